seq_booth_multiplier: RTL
=========================

Name: seq_booth_multiplier

Overview:
- Iterative radix-2 Booth multiplier, parametrised successor to the combinational 8-bit Booth array.
- Performs one add/sub-and-arithmetic-shift step per clock, so one adder serves any WIDTH.
- Adds a per-operation signed/unsigned mode and valid/ready handshakes on both input and output.
- Serves as the shared multiply unit behind the datapath ALU.

Parameters:
- WIDTH, 8, operand width in bits; legal values are WIDTH >= 2. Product width is 2*WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands present
- in_ready  out  1  block can accept operands
- is_signed  in  1  1 = two's-complement operands, 0 = unsigned; sampled with operands
- multiplicand  in  WIDTH  operand M
- multiplier  in  WIDTH  operand Q
- out_valid  out  1  product valid
- out_ready  in  1  consumer accepts product
- product  out  2*WIDTH  result register
- busy  out  1  high in RUN state

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE, in_ready = 1, out_valid = 0, busy = 0, product = 0, all internal registers = 0.
- Internal working width is E = WIDTH+1.
  - Operands are extended by one bit: sign-extended if is_signed = 1, zero-extended if is_signed = 0.
  - Registers: A[E], Q[E], q_1, M[E], step counter (clog2(E+1) bits).
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready at a clock edge: load A = 0, Q = ext(multiplier), q_1 = 0, M = ext(multiplicand), count = E. Go to RUN.
  - is_signed and operands are latched; later input changes are ignored.
- RUN (busy = 1, in_ready = 0): each cycle performs one Booth step.
  - {Q[0],q_1} = 01 -> A + M; 10 -> A - M (two's complement); 00/11 -> A unchanged.
  - Then arithmetic right shift of {A', Q, q_1} by one, replicating the MSB of A'.
  - count decrements each cycle.
  - On the step where count = 1: latch product = low 2*WIDTH bits of the shifted {A,Q} (2E bits), go to DONE, out_valid = 1.
- Latency: exactly E cycles from the accepting edge to the edge that raises out_valid (9 cycles for WIDTH = 8).
- DONE:
  - out_valid = 1; in_ready = 0; busy = 0.
  - product holds stable until out_valid && out_ready at an edge, then go to IDLE with out_valid = 0.
  - No input is accepted in the same cycle as the output handoff.
- product register retains its last value after handoff; it changes only on completion or reset.
- in_valid asserted while in RUN or DONE is ignored; nothing is queued.
- Arithmetic: the full product always fits in 2*WIDTH bits for both modes, so there is no overflow.
  - Signed result is two's complement; unsigned result is a plain binary magnitude.
  - Corner cases -2^(WIDTH-1) * -2^(WIDTH-1) and (2^WIDTH-1)^2 must be exact.
- Reset mid-RUN or mid-DONE: immediate return to IDLE with the reset values above; the in-flight operation is discarded.
- The adder may be an E-bit add/sub built from xor2/fa cells or behavioural; the cycle behaviour is what is normative.

Test Plan:
- WIDTH=8, signed, -128 * -128 -> after 9 cycles out_valid=1, product = 0x4000 (16384); busy high exactly 9 cycles.
- WIDTH=8, unsigned, 255 * 255 -> product = 0xFE01; signed, 7 * -3 -> product = 0xFFEB (-21).
- WIDTH=8, operands 0x80 and 0x02: unsigned -> 0x0100; signed -> 0xFF00. Also check 0 * any -> 0x0000.
- Backpressure: hold out_ready=0 for 5 cycles after completion -> out_valid and product stable; in_ready=0 throughout. Pulse out_ready -> IDLE next cycle, in_ready=1.
- Second in_valid with different operands during RUN -> ignored; first product unchanged. Back-to-back ops complete in order with correct results.
- Assert rst_n=0 for 1 cycle at step 4 of a run -> out_valid=0, product=0, in_ready=1 immediately. A new op then completes correctly. Run a random sweep of 1000 ops per mode for WIDTH=4, 8, 16 against a behavioural reference.

Source files
------------

// File: rtl/seq_booth_multiplier.sv
// Iterative radix-2 Booth multiplier with signed/unsigned mode and valid/ready on both sides.
// Handles one add/sub plus one arithmetic shift per clock over a WIDTH+1 bit working width.
module seq_booth_multiplier #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int unsigned E  = WIDTH + 1;
  localparam int unsigned CW = $clog2(E + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic           in_ready_d, out_valid_d, busy_d;

  logic [E-1:0]   a_q, q_q, m_q;
  logic           q1_q;
  logic [CW-1:0]  cnt_q;

  logic [E-1:0]   m_ext_c, q_ext_c;
  logic [E-1:0]   a_sum_c, a_sh_c, q_sh_c;
  logic           last_step_c;

  // Operand extension: the extra bit makes unsigned magnitudes look positive to Booth.
  assign m_ext_c = {is_signed & multiplicand[WIDTH-1], multiplicand};
  assign q_ext_c = {is_signed & multiplier[WIDTH-1], multiplier};

  assign last_step_c = (cnt_q == CW'(1));

  // One Booth step: conditional add/sub of M, then arithmetic right shift of {A,Q,q_1}.
  always_comb begin
    a_sum_c = a_q;
    case ({q_q[0], q1_q})
      2'b01:   a_sum_c = a_q + m_q;
      2'b10:   a_sum_c = a_q - m_q;
      default: a_sum_c = a_q;
    endcase
    a_sh_c = {a_sum_c[E-1], a_sum_c[E-1:1]};
    q_sh_c = {a_sum_c[0], q_q[E-1:1]};
  end

  // State register and registered handshake/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      busy      <= busy_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid)    state_d = S_RUN;
      S_RUN:   if (last_step_c) state_d = S_DONE;
      S_DONE:  if (out_ready)   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state so the outputs come straight out of flops.
  always_comb begin
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    busy_d      = 1'b0;
    case (state_d)
      S_IDLE:  in_ready_d  = 1'b1;
      S_RUN:   busy_d      = 1'b1;
      S_DONE:  out_valid_d = 1'b1;
      default: in_ready_d  = 1'b1;
    endcase
  end

  // Datapath: load on accept, step while running, latch the product on the final step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      m_q     <= '0;
      cnt_q   <= '0;
      product <= '0;
    end else begin
      if (state_q == S_IDLE && in_valid) begin
        a_q   <= '0;
        q_q   <= q_ext_c;
        q1_q  <= 1'b0;
        m_q   <= m_ext_c;
        cnt_q <= CW'(E);
      end else if (state_q == S_RUN) begin
        a_q   <= a_sh_c;
        q_q   <= q_sh_c;
        q1_q  <= q_q[0];
        cnt_q <= cnt_q - CW'(1);
        if (last_step_c) begin
          product <= {a_sh_c[E-3:0], q_sh_c};
        end
      end
    end
  end

endmodule
